// File: rtl/note_pkg.sv
// Shared constants for the note quantizer: FSM encoding, octave-4 boundary table,
// semitone indices and octave limits.
package note_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_NORM = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int BOUND_W = 20;

  // Period boundaries (samples x16) halfway between semitones around C4..B4.
  localparam logic [BOUND_W-1:0] BOUND [0:12] = '{
    20'd3022, 20'd2853, 20'd2693, 20'd2541, 20'd2399, 20'd2264, 20'd2137,
    20'd2017, 20'd1904, 20'd1797, 20'd1696, 20'd1601, 20'd1511
  };

  localparam logic [3:0] NOTE_C  = 4'd0;
  localparam logic [3:0] NOTE_CS = 4'd1;
  localparam logic [3:0] NOTE_D  = 4'd2;
  localparam logic [3:0] NOTE_DS = 4'd3;
  localparam logic [3:0] NOTE_E  = 4'd4;
  localparam logic [3:0] NOTE_F  = 4'd5;
  localparam logic [3:0] NOTE_FS = 4'd6;
  localparam logic [3:0] NOTE_G  = 4'd7;
  localparam logic [3:0] NOTE_GS = 4'd8;
  localparam logic [3:0] NOTE_A  = 4'd9;
  localparam logic [3:0] NOTE_AS = 4'd10;
  localparam logic [3:0] NOTE_B  = 4'd11;

  localparam logic signed [4:0] REF_OCT = 5'sd4;
  localparam logic signed [4:0] MAX_OCT = 5'sd9;

endpackage

// File: rtl/note_bound_rom.sv
// Combinational lookup of one entry of the semitone boundary table.
module note_bound_rom
  import note_pkg::*;
(
  input  logic [3:0]         idx,
  output logic [BOUND_W-1:0] bound
);

  always_comb begin
    bound = '0;
    if (idx <= 4'd12) bound = BOUND[idx];
  end

endmodule

// File: rtl/note_quantizer.sv
// Pitch period -> semitone/octave converter: shift-normalise into octave 4, then linear table scan.
// Optional macro NOTE_DEBOUNCE_EN: held outputs only follow a result repeated twice in a row.
module note_quantizer
  import note_pkg::*;
#(
  parameter int PERIOD_W = 16,
  parameter int FRAC_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PERIOD_W-1:0] period_in,
  output logic                note_valid,
  output logic                note_err,
  output logic [3:0]          note_name,
  output logic [3:0]          note_octave
);

  localparam int X_W = PERIOD_W + FRAC_W;
  localparam logic [X_W-1:0] B_HI = X_W'(BOUND[0]);
  localparam logic [X_W-1:0] B_LO = X_W'(BOUND[12]);

  logic [1:0]         state;
  logic [X_W-1:0]     x;
  logic signed [4:0]  oct;
  logic [3:0]         idx;
  logic [3:0]         idx_nxt;
  logic [BOUND_W-1:0] bound_nxt;
  logic [X_W-1:0]     bound_x;
  logic               too_long;
  logic               too_short;
  logic               err_hit;
  logic               ok_hit;
  logic               take_result;

  note_bound_rom u_rom (
    .idx   (idx_nxt),
    .bound (bound_nxt)
  );

  always_comb begin
    idx_nxt   = idx + 4'd1;
    bound_x   = X_W'(bound_nxt);
    too_long  = x > B_HI;
    too_short = x <= B_LO;
    ok_hit    = (state == ST_SCAN) && (x > bound_x);
    err_hit   = 1'b0;
    if (state == ST_IDLE)
      err_hit = in_valid && (period_in == '0);
    else if (state == ST_NORM)
      err_hit = (too_long && (oct == 5'sd0)) || (!too_long && too_short && (oct == MAX_OCT));
  end

  assign in_ready = (state == ST_IDLE);

`ifdef NOTE_DEBOUNCE_EN
  logic       cand_vld;
  logic [3:0] cand_name;
  logic [3:0] cand_oct;

  assign take_result = cand_vld && (cand_name == idx) && (cand_oct == oct[3:0]);

  // Candidate remembers the last successful result; errors invalidate it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_vld  <= 1'b0;
      cand_name <= '0;
      cand_oct  <= '0;
    end else if (err_hit) begin
      cand_vld <= 1'b0;
    end else if (ok_hit) begin
      cand_vld  <= 1'b1;
      cand_name <= idx;
      cand_oct  <= oct[3:0];
    end
  end
`else
  assign take_result = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      x           <= '0;
      oct         <= '0;
      idx         <= '0;
      note_valid  <= 1'b0;
      note_err    <= 1'b0;
      note_name   <= '0;
      note_octave <= '0;
    end else begin
      note_valid <= 1'b0;
      if (err_hit) begin
        // Held name/octave stay untouched on any error exit.
        note_valid <= 1'b1;
        note_err   <= 1'b1;
        state      <= ST_DONE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (in_valid) begin
              x     <= {period_in, {FRAC_W{1'b0}}};
              oct   <= REF_OCT;
              state <= ST_NORM;
            end
          end
          ST_NORM: begin
            if (too_long) begin
              x   <= x >> 1;
              oct <= oct - 5'sd1;
            end else if (too_short) begin
              x   <= x << 1;
              oct <= oct + 5'sd1;
            end else begin
              idx   <= '0;
              state <= ST_SCAN;
            end
          end
          ST_SCAN: begin
            if (ok_hit) begin
              note_valid <= 1'b1;
              note_err   <= 1'b0;
              state      <= ST_DONE;
              if (take_result) begin
                note_name   <= idx;
                note_octave <= oct[3:0];
              end
            end else begin
              idx <= idx_nxt;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_quantizer.sv
// Randomised and directed bench for note_quantizer against a band-search reference model.
module tb_note_quantizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] period_in = '0;
  logic        note_valid;
  logic        note_err;
  logic [3:0]  note_name;
  logic [3:0]  note_octave;

  int checks = 0;
  int failures = 0;

  localparam int BND [0:12] = '{3022, 2853, 2693, 2541, 2399, 2264, 2137,
                                2017, 1904, 1797, 1696, 1601, 1511};

  // Reference model state: what the display should currently hold.
  int h_name = 0;
  int h_oct = 0;
  bit cand_v = 0;
  int cand_name = 0;
  int cand_oct = 0;

  // Values captured at the strobe.
  logic o_err;
  int   o_name;
  int   o_oct;

  note_quantizer #(.PERIOD_W(16), .FRAC_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .period_in   (period_in),
    .note_valid  (note_valid),
    .note_err    (note_err),
    .note_name   (note_name),
    .note_octave (note_octave)
  );

  always #5 clk = ~clk;

  function automatic int abs_i(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Find the octave whose scaled period lands in (1511, 3022], then the semitone bin.
  task automatic model_conv(input int p, output bit e, output int nm, output int oc, output int lat);
    longint x, t, y;
    int o_f, k;
    bit found;
    found = 0; o_f = 0; y = 0; k = 0; e = 0; lat = 0;
    if (p == 0) begin
      e = 1;
      lat = 0;
    end else begin
      x = longint'(p) * 16;
      for (int o = 0; o <= 9; o++) begin
        t = (o >= 4) ? (x << (o - 4)) : (x >> (4 - o));
        if (t > 1511 && t <= 3022) begin
          found = 1; o_f = o; y = t;
        end
      end
      if (found) begin
        for (int i = 0; i < 12; i++)
          if (y <= BND[i] && y > BND[i+1]) k = i;
        lat = abs_i(o_f - 4) + k + 2;
`ifdef NOTE_DEBOUNCE_EN
        if (cand_v && cand_name == k && cand_oct == o_f) begin
          h_name = k; h_oct = o_f;
        end
        cand_v = 1; cand_name = k; cand_oct = o_f;
`else
        h_name = k; h_oct = o_f;
`endif
      end else begin
        e = 1;
        lat = ((x >> 4) > 3022) ? 5 : 6;
      end
    end
    if (e) cand_v = 0;
    nm = h_name;
    oc = h_oct;
  endtask

  task automatic model_reset();
    h_name = 0; h_oct = 0; cand_v = 0; cand_name = 0; cand_oct = 0;
  endtask

  task automatic start_conv(input int p, output bit to);
    int w;
    to = 0; w = 0;
    @(negedge clk);
    while (!in_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      to = 1;
    end else begin
      in_valid = 1'b1;
      period_in = 16'(p);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // Counts edges after the accepting edge until the strobe; optionally pokes in_valid while busy.
  task automatic wait_result(input int n_poke, output int lat, output bit to, output logic vnext);
    lat = 0; to = 0;
    in_valid = (n_poke > 0);
    if (n_poke > 0) period_in = 16'd183;
    while (!note_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      in_valid = (lat < n_poke);
    end
    in_valid = 1'b0;
    if (!note_valid) to = 1;
    o_err = note_err;
    o_name = int'(note_name);
    o_oct = int'(note_octave);
    @(posedge clk);
    #1;
    vnext = note_valid;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    period_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (note_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", note_valid); end
    checks++; if (note_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", note_err); end
    checks++; if (note_name !== 4'd0) begin failures++; $display("FAIL reset_name got=%0d exp=0", note_name); end
    checks++; if (note_octave !== 4'd0) begin failures++; $display("FAIL reset_oct got=%0d exp=0", note_octave); end
  endtask

  task automatic test_directed();
    int ps [0:6] = '{183, 367, 109, 119, 106, 189, 94};
    bit e, to; int nm, oc, el, lat; logic vn;
    foreach (ps[i]) begin
      model_conv(ps[i], e, nm, oc, el);
      start_conv(ps[i], to);
      wait_result(0, lat, to, vn);
      checks++; if (to || o_err !== e) begin failures++; $display("FAIL dir_err p=%0d got=%0b exp=%0b to=%0b", ps[i], o_err, e, to); end
      checks++; if (o_name !== nm) begin failures++; $display("FAIL dir_name p=%0d got=%0d exp=%0d", ps[i], o_name, nm); end
      checks++; if (o_oct !== oc) begin failures++; $display("FAIL dir_oct p=%0d got=%0d exp=%0d", ps[i], o_oct, oc); end
      checks++; if (lat !== el) begin failures++; $display("FAIL dir_latency p=%0d got=%0d exp=%0d", ps[i], lat, el); end
      checks++; if (vn !== 1'b0) begin failures++; $display("FAIL dir_pulse_width p=%0d got=%0b exp=0", ps[i], vn); end
    end
  endtask

  task automatic test_errors();
    int ps [0:3] = '{0, 1, 5000, 183};
    bit e, to; int nm, oc, el, lat; logic vn;
    foreach (ps[i]) begin
      model_conv(ps[i], e, nm, oc, el);
      start_conv(ps[i], to);
      wait_result(0, lat, to, vn);
      checks++; if (to || o_err !== e) begin failures++; $display("FAIL err_flag p=%0d got=%0b exp=%0b to=%0b", ps[i], o_err, e, to); end
      checks++; if (o_name !== nm || o_oct !== oc) begin failures++; $display("FAIL err_held p=%0d got=%0d/%0d exp=%0d/%0d", ps[i], o_name, o_oct, nm, oc); end
      checks++; if (lat !== el) begin failures++; $display("FAIL err_latency p=%0d got=%0d exp=%0d", ps[i], lat, el); end
    end
  endtask

  task automatic test_back_to_back();
    bit e, to; int nm, oc, el, lat, extra; logic vn;
    model_conv(109, e, nm, oc, el);
    start_conv(109, to);
    wait_result(5, lat, to, vn);
    checks++; if (to || o_err !== e || o_name !== nm || o_oct !== oc) begin failures++; $display("FAIL busy_result got=%0b/%0d/%0d exp=%0b/%0d/%0d", o_err, o_name, o_oct, e, nm, oc); end
    checks++; if (lat !== el) begin failures++; $display("FAIL busy_latency got=%0d exp=%0d", lat, el); end
    extra = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (note_valid) extra++;
    end
    checks++; if (extra !== 0 || in_ready !== 1'b1) begin failures++; $display("FAIL busy_no_accept strobes=%0d in_ready=%0b exp=0/1", extra, in_ready); end
  endtask

  task automatic test_reset_mid();
    bit e, to; int nm, oc, el, lat, strobes; logic vn;
    model_conv(109, e, nm, oc, el);
    start_conv(109, to);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (note_valid !== 1'b0 || note_err !== 1'b0) begin failures++; $display("FAIL rstmid_flags got=%0b/%0b exp=0/0", note_valid, note_err); end
    checks++; if (note_name !== 4'd0 || note_octave !== 4'd0) begin failures++; $display("FAIL rstmid_held got=%0d/%0d exp=0/0", note_name, note_octave); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%0b exp=1", in_ready); end
    strobes = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (note_valid) strobes++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (12) begin
      @(posedge clk);
      #1;
      if (note_valid) strobes++;
    end
    checks++; if (strobes !== 0) begin failures++; $display("FAIL rstmid_no_strobe got=%0d exp=0", strobes); end
    model_conv(183, e, nm, oc, el);
    start_conv(183, to);
    wait_result(0, lat, to, vn);
    checks++; if (to || o_err !== e || o_name !== nm || o_oct !== oc || lat !== el) begin failures++; $display("FAIL rstmid_next got=%0b/%0d/%0d/%0d exp=%0b/%0d/%0d/%0d", o_err, o_name, o_oct, lat, e, nm, oc, el); end
  endtask

  task automatic test_random();
    bit e, to; int p, nm, oc, el, lat; logic vn;
    for (int i = 0; i < 30; i++) begin
      p = (i % 5 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(1, 3500));
      model_conv(p, e, nm, oc, el);
      start_conv(p, to);
      wait_result(0, lat, to, vn);
      checks++; if (to || o_err !== e || o_name !== nm || o_oct !== oc) begin failures++; $display("FAIL rand_result p=%0d got=%0b/%0d/%0d exp=%0b/%0d/%0d", p, o_err, o_name, o_oct, e, nm, oc); end
      checks++; if (lat !== el || vn !== 1'b0) begin failures++; $display("FAIL rand_timing p=%0d lat=%0d exp=%0d next_valid=%0b", p, lat, el, vn); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
